// File: rtl/rx_iq_buffer.sv
// Receive-path I/Q sample FIFO feeding the STM32 parallel-bus interface; pops on snooped RX IQ read commands.
// Optional drop counter enabled with `define RX_IQ_BUF_DROP_CNT_EN.
module rx_iq_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 16
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] in_I,
    input  logic signed [WIDTH-1:0] in_Q,
    input  logic                    in_valid,
    input  logic [3:0]              DATA_IN,
    input  logic                    DATA_SYNC,
    output logic signed [WIDTH-1:0] I,
    output logic signed [WIDTH-1:0] Q,
    output logic [DEPTH_LOG2:0]     fifo_level,
    output logic                    overflow,
    output logic                    underflow
`ifdef RX_IQ_BUF_DROP_CNT_EN
    ,
    output logic [15:0]             drop_count
`endif
);

    localparam int unsigned PTR_W   = DEPTH_LOG2;
    localparam int unsigned LVL_W   = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned ENTRY_W = 2 * WIDTH;
    localparam logic [3:0]  CMD_RX_IQ  = 4'd4;
    localparam logic [3:0]  CMD_PARAMS = 4'd2;

    logic [ENTRY_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]        wptr;
    logic [PTR_W-1:0]        rptr;
    logic signed [WIDTH-1:0] head_i;
    logic signed [WIDTH-1:0] head_q;

    logic push;
    logic pop_req;
    logic clr_req;
    logic empty;
    logic full;
    logic do_pop;
    logic do_write;
    logic bypass;
    logic drop;
    logic uf_set;

    // Command decode and FIFO control
    always_comb begin
        push     = in_valid;
        pop_req  = DATA_SYNC && (DATA_IN == CMD_RX_IQ);
        clr_req  = DATA_SYNC && (DATA_IN == CMD_PARAMS);
        empty    = (fifo_level == '0);
        full     = (fifo_level == LVL_W'(DEPTH));
        do_pop   = pop_req && !empty;
        bypass   = pop_req && empty && push;
        uf_set   = pop_req && empty && !push;
        drop     = push && full && !pop_req;
        do_write = push && !bypass && (!full || do_pop);
    end

    assign head_i = $signed(mem[rptr][ENTRY_W-1:WIDTH]);
    assign head_q = $signed(mem[rptr][WIDTH-1:0]);

    // Sample storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clk_in) begin
        if (do_write) begin
            mem[wptr] <= {in_I, in_Q};
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            I          <= '0;
            Q          <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (do_write) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PTR_W'(1);
                I    <= head_i;
                Q    <= head_q;
            end else if (bypass) begin
                I    <= in_I;
                Q    <= in_Q;
            end
            if (do_write && !do_pop) begin
                fifo_level <= fifo_level + LVL_W'(1);
            end else if (do_pop && !do_write) begin
                fifo_level <= fifo_level - LVL_W'(1);
            end
            // Sticky flags: a set on the clear cycle wins
            overflow  <= drop   || (overflow  && !clr_req);
            underflow <= uf_set || (underflow && !clr_req);
        end
    end

`ifdef RX_IQ_BUF_DROP_CNT_EN
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (clr_req) begin
            drop_count <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    // No drop counter in this build
`endif

endmodule

// File: tb/tb_rx_iq_buffer.sv
// Randomized self-checking bench for rx_iq_buffer against a queue-based reference model.
module tb_rx_iq_buffer;

    localparam int DEPTH = 16;

    logic               clk_in = 1'b0;
    logic               reset_n;
    logic signed [15:0] in_I;
    logic signed [15:0] in_Q;
    logic               in_valid;
    logic [3:0]         DATA_IN;
    logic               DATA_SYNC;
    logic signed [15:0] I;
    logic signed [15:0] Q;
    logic [4:0]         fifo_level;
    logic               overflow;
    logic               underflow;
`ifdef RX_IQ_BUF_DROP_CNT_EN
    logic [15:0]        drop_count;
`endif

    always #5 clk_in = ~clk_in;

    rx_iq_buffer #(.DEPTH_LOG2(4), .WIDTH(16)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .in_I       (in_I),
        .in_Q       (in_Q),
        .in_valid   (in_valid),
        .DATA_IN    (DATA_IN),
        .DATA_SYNC  (DATA_SYNC),
        .I          (I),
        .Q          (Q),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .underflow  (underflow)
`ifdef RX_IQ_BUF_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [15:0] m_i;
    logic [15:0] m_q;
    logic        m_of;
    logic        m_uf;
    int          m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_i    = '0;
        m_q    = '0;
        m_of   = 1'b0;
        m_uf   = 1'b0;
        m_drop = 0;
    endtask

    task automatic check_all();
        check("I", {16'h0, I}, {16'h0, m_i});
        check("Q", {16'h0, Q}, {16'h0, m_q});
        check("fifo_level", {27'h0, fifo_level}, 32'(mq.size()));
        check("overflow", {31'h0, overflow}, {31'h0, m_of});
        check("underflow", {31'h0, underflow}, {31'h0, m_uf});
`ifdef RX_IQ_BUF_DROP_CNT_EN
        check("drop_count", {16'h0, drop_count}, 32'(m_drop));
`endif
    endtask

    // One clock of stimulus: drive at negedge, update model, check after the rising edge
    task automatic cycle(input logic push, input logic [15:0] di, input logic [15:0] dq,
                         input logic sync, input logic [3:0] nib);
        logic        pop_r;
        logic        clr_r;
        logic        ov_s;
        logic        uf_s;
        logic [31:0] e;
        @(negedge clk_in);
        in_valid  = push;
        in_I      = di;
        in_Q      = dq;
        DATA_SYNC = sync;
        DATA_IN   = nib;
        pop_r = sync && (nib == 4'd4);
        clr_r = sync && (nib == 4'd2);
        ov_s  = 1'b0;
        uf_s  = 1'b0;
        if (pop_r) begin
            if (mq.size() > 0) begin
                e   = mq.pop_front();
                m_i = e[31:16];
                m_q = e[15:0];
                if (push) mq.push_back({di, dq});
            end else if (push) begin
                m_i = di;
                m_q = dq;
            end else begin
                uf_s = 1'b1;
            end
        end else if (push) begin
            if (mq.size() < DEPTH) mq.push_back({di, dq});
            else ov_s = 1'b1;
        end
        m_of = ov_s || (m_of && !clr_r);
        m_uf = uf_s || (m_uf && !clr_r);
        if (clr_r) m_drop = ov_s ? 1 : 0;
        else if (ov_s && m_drop < 65535) m_drop++;
        @(posedge clk_in);
        #1;
        check_all();
    endtask

    task automatic rd();
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 4'd4);
    endtask

    task automatic wr(input logic [15:0] di, input logic [15:0] dq);
        cycle(1'b1, di, dq, 1'b0, 4'(($urandom_range(15))));
    endtask

    initial begin
        int unsigned r;
        int unsigned pp;
        logic        s;
        logic [3:0]  nb;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_I      = '0;
        in_Q      = '0;
        DATA_SYNC = 1'b0;
        DATA_IN   = 4'd0;
        model_reset();
        #3;
        check_all();
        @(negedge clk_in);
        reset_n = 1'b1;

        // Three pairs in, three reads out
        for (int k = 1; k <= 3; k++) wr(16'(k), 16'(0 - k));
        for (int k = 0; k < 3; k++) rd();

        // Overfill by one, then drain
        for (int k = 1; k <= 17; k++) wr(16'(k), 16'(k) ^ 16'hA5A5);
        for (int k = 0; k < 16; k++) rd();

        // Underflow then clear via params readout
        rd();
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 4'd2);

        // Bypass on empty FIFO
        cycle(1'b1, 16'h7FFF, 16'h8000, 1'b1, 4'd4);

        // Full FIFO with simultaneous push/read across pointer wrap
        for (int k = 0; k < 16; k++) wr(16'($urandom), 16'($urandom));
        for (int k = 0; k < 20; k++) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b1, 4'd4);
        // Drop on the clear cycle: set wins
        cycle(1'b1, 16'h1234, 16'h5678, 1'b1, 4'd2);
        cycle(1'b0, 16'h0, 16'h0, 1'b1, 4'd9);
        for (int k = 0; k < 16; k++) rd();

        // Asynchronous reset with level 5
        for (int k = 0; k < 5; k++) wr(16'($urandom), 16'($urandom));
        in_valid  = 1'b0;
        DATA_SYNC = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk_in);
        reset_n = 1'b1;
        rd();

        // Randomized traffic with varying fill pressure
        for (int c = 0; c < 900; c++) begin
            pp = (c / 100) % 3 == 0 ? 80 : ((c / 100) % 3 == 1 ? 50 : 20);
            s  = ($urandom_range(99) < 40);
            r  = $urandom_range(99);
            nb = (r < 60) ? 4'd4 : ((r < 75) ? 4'd2 : 4'($urandom_range(15)));
            cycle($urandom_range(99) < pp, 16'($urandom), 16'($urandom), s, nb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rx_iq_buffer.md
Name: rx_iq_buffer

Overview:
Sample FIFO placed directly upstream of the STM32 parallel-bus interface on the receive path. It absorbs decimated I/Q samples from the DDC chain, which arrive with a valid strobe. It pops one sample per RX IQ read command snooped from the STM32 bus (DATA_SYNC with DATA_IN=4). The popped sample is held on I/Q outputs, stable for the 8-nibble readout that follows.

Parameters:
DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 sample pairs (16)
WIDTH, 16, signed sample width of I and Q

Ports:
clk_in  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous active-low reset
in_I  input  WIDTH  signed I sample from DDC decimator
in_Q  input  WIDTH  signed Q sample from DDC decimator
in_valid  input  1  one-cycle strobe; in_I/in_Q valid this cycle
DATA_IN  input  4  STM32 bus nibble (snooped, read-only)
DATA_SYNC  input  1  STM32 command strobe (snooped)
I  output  WIDTH  held I sample presented to the bus interface
Q  output  WIDTH  held Q sample presented to the bus interface
fifo_level  output  DEPTH_LOG2+1  stored sample pairs, 0..2^DEPTH_LOG2
overflow  output  1  sticky: a sample was dropped because the FIFO was full
underflow  output  1  sticky: a read command arrived while the FIFO was empty

Behaviour:
- Reset (async assert, sync release): I=0, Q=0, fifo_level=0, overflow=0, underflow=0, read/write pointers=0. Stored contents are don't-care.
- Storage: circular buffer, I and Q stored as a pair, binary pointers of DEPTH_LOG2 bits that wrap modulo depth. Level counter is DEPTH_LOG2+1 bits.
- push = in_valid. pop_req = DATA_SYNC && DATA_IN==4. clr_req = DATA_SYNC && DATA_IN==2 (params readout).
- pop_req, FIFO non-empty: on the same edge, I/Q <= head entry, rptr+1, level-1. The bus interface samples I/Q on the following edge, so I/Q must be registered by the end of the pop_req cycle.
- pop_req, FIFO empty, no push: I/Q hold their previous value; underflow <= 1.
- pop_req, FIFO empty, with push: bypass. I/Q <= in_I/in_Q directly, nothing stored, level stays 0, no underflow.
- push, not full, no pop: write at wptr, wptr+1, level+1.
- push, full, no pop: sample discarded; overflow <= 1; pointers and level unchanged.
- push and pop, FIFO full: both take effect, level stays at depth, no overflow.
- push and pop, 0 < level < depth: both take effect, level unchanged.
- clr_req: clears overflow and underflow. If a set condition occurs on the same cycle, set wins.
- DATA_SYNC with any other DATA_IN value: ignored. DATA_IN is not examined when DATA_SYNC=0.
- I/Q change only on a pop, a bypass, or reset.
- Reset mid-operation: all queued samples are lost and outputs return to reset values immediately (async).

Optional Feature:
Macro RX_IQ_BUF_DROP_CNT_EN.
- Defined: adds output drop_count [15:0], reset 0. It increments once per discarded push (full, no pop), saturates at 65535, and is cleared by clr_req. Increment wins over clear on the same cycle, giving a result of 1.
- Undefined: the port does not exist and no counter logic is built.

Test Plan:
- Reset, push 3 pairs (I=1,2,3; Q=-1,-2,-3), then 3 read commands -> I/Q = (1,-1),(2,-2),(3,-3) one edge after each DATA_SYNC; fifo_level 3->0; no flags set.
- Push 17 pairs with no reads -> fifo_level=16, overflow=1; 16 reads return samples 1..16; the 17th sample is never output.
- Read with FIFO empty and in_valid=0 -> I/Q unchanged, underflow=1. Then DATA_SYNC with DATA_IN=2 -> underflow=0.
- Read with FIFO empty and in_valid=1 on the same cycle with (0x7FFF,0x8000) -> I=0x7FFF, Q=0x8000 next cycle, fifo_level stays 0, underflow=0.
- Fill to 16, then push+read on the same cycle for 20 cycles -> level stays 16, no overflow, outputs in FIFO order across pointer wrap. With RX_IQ_BUF_DROP_CNT_EN, drop_count stays 0.
- Assert reset_n=0 mid-stream with level=5 -> I/Q/level/flags go to 0 without waiting for a clock edge; the next read after release sets underflow=1.
